// File: rtl/debounce_pkg.sv
// debounce_pkg: shared FSM state encoding for the input debouncer.
package debounce_pkg;
  typedef enum logic [1:0] {IDLE_LO, CHK_HI, IDLE_HI, CHK_LO} state_t;
endpackage

// File: rtl/sync_chain.sv
// sync_chain: multi-flop synchroniser for an asynchronous single-bit input.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d_i};
  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: synchronises and debounces a raw input, emits level, edge strobes and a glitch count.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_raw,
  input  logic                clr_glitch,
  output logic                level,
  output logic                rise,
  output logic                fall,
  output logic [GLITCH_W-1:0] glitch_cnt
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic ONE_SHOT = (STABLE_CYCLES == 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic level_q, level_d, rise_q, rise_d, fall_q, fall_d;
  logic a_s, glitch;
  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .d_i(a_raw),
    .q_o(a_s)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    glitch  = 1'b0;
    cnt_inc = cnt_q + CW'(1);
    case (state_q)
      IDLE_LO: if (a_s) begin
        state_d = ONE_SHOT ? IDLE_HI : CHK_HI;
        cnt_d   = ONE_SHOT ? '0 : CW'(1);
      end
      CHK_HI: if (a_s) begin
        state_d = (cnt_inc == CNT_MAX) ? IDLE_HI : CHK_HI;
        cnt_d   = (cnt_inc == CNT_MAX) ? '0 : cnt_inc;
      end else begin
        state_d = IDLE_LO;
        cnt_d   = '0;
        glitch  = 1'b1;
      end
      IDLE_HI: if (!a_s) begin
        state_d = ONE_SHOT ? IDLE_LO : CHK_LO;
        cnt_d   = ONE_SHOT ? '0 : CW'(1);
      end
      CHK_LO: if (!a_s) begin
        state_d = (cnt_inc == CNT_MAX) ? IDLE_LO : CHK_LO;
        cnt_d   = (cnt_inc == CNT_MAX) ? '0 : cnt_inc;
      end else begin
        state_d = IDLE_HI;
        cnt_d   = '0;
        glitch  = 1'b1;
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
    endcase
    // edges are judged against the accepted level, so glitch returns never strobe
    level_d  = (state_d == IDLE_HI) || (state_d == CHK_LO);
    rise_d   = (state_d == IDLE_HI) && !level_q;
    fall_d   = (state_d == IDLE_LO) && level_q;
    glitch_d = clr_glitch ? '0 : (glitch && !(&glitch_q)) ? glitch_q + GLITCH_W'(1) : glitch_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE_LO;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  assign level      = level_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign glitch_cnt = glitch_q;
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: three debouncer configurations driven by one stimulus stream, checked against a run-length model.
module tb_input_debouncer;
  logic clk = 1'b0, rst = 1'b1, a_raw = 1'b0, clr_glitch = 1'b0;
  logic [2:0] lv, rs, fl;
  logic [7:0] g0;
  logic [1:0] g1, g2;
  int n_checks = 0, n_errors = 0;
  logic [1:0] syn;
  int m_lvl[3], m_run[3], m_gl[3], m_rise[3], m_fall[3];

  always #5 clk = ~clk;

  input_debouncer u0 (
    .clk(clk), .rst(rst), .a_raw(a_raw), .clr_glitch(clr_glitch),
    .level(lv[0]), .rise(rs[0]), .fall(fl[0]), .glitch_cnt(g0)
  );
  input_debouncer #(.GLITCH_W(2)) u1 (
    .clk(clk), .rst(rst), .a_raw(a_raw), .clr_glitch(clr_glitch),
    .level(lv[1]), .rise(rs[1]), .fall(fl[1]), .glitch_cnt(g1)
  );
  input_debouncer #(.STABLE_CYCLES(1), .GLITCH_W(2)) u2 (
    .clk(clk), .rst(rst), .a_raw(a_raw), .clr_glitch(clr_glitch),
    .level(lv[2]), .rise(rs[2]), .fall(fl[2]), .glitch_cnt(g2)
  );

  function automatic int st_of(int i);
    return (i == 2) ? 1 : 4;
  endfunction
  function automatic int gmax_of(int i);
    return (i == 0) ? 255 : 3;
  endfunction
  function automatic logic [31:0] gdut(int i);
    return (i == 0) ? 32'(g0) : (i == 1) ? 32'(g1) : 32'(g2);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    syn = '0;
    for (int i = 0; i < 3; i++) begin
      m_lvl[i] = 0; m_run[i] = 0; m_gl[i] = 0; m_rise[i] = 0; m_fall[i] = 0;
    end
  endtask

  // level flips only after st_of(i) consecutive disagreeing synced samples; a shorter run is a glitch
  task automatic model_step(input logic a, input logic c);
    int s;
    bit evt;
    s = int'(syn[1]);
    syn = {syn[0], a};
    for (int i = 0; i < 3; i++) begin
      evt = 0;
      m_rise[i] = 0;
      m_fall[i] = 0;
      if (s != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] >= st_of(i)) begin
          m_lvl[i] = s; m_rise[i] = s; m_fall[i] = 1 - s; m_run[i] = 0;
        end
      end else begin
        evt = (m_run[i] > 0);
        m_run[i] = 0;
      end
      if (c) m_gl[i] = 0;
      else if (evt && m_gl[i] < gmax_of(i)) m_gl[i]++;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("level%0d", i), 32'(lv[i]), m_lvl[i]);
      check($sformatf("rise%0d", i), 32'(rs[i]), m_rise[i]);
      check($sformatf("fall%0d", i), 32'(fl[i]), m_fall[i]);
      check($sformatf("glitch%0d", i), gdut(i), m_gl[i]);
    end
  endtask

  task automatic cyc(input logic a, input logic c);
    a_raw = a;
    clr_glitch = c;
    @(posedge clk);
    #1;
    model_step(a, c);
    compare_all();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    #1 compare_all();
    check("async_level0", 32'(lv[0]), 0);
    check("async_glitch0", 32'(g0), 0);
    #2 rst = 1'b0;
  endtask

  initial begin
    int r, f;
    logic h[$];
    logic bounce[9];
    logic a;
    bounce = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
    model_reset();
    #12;
    compare_all();
    check("reset_level", 32'(lv[0]), 0);
    rst = 1'b0;

    for (int j = 0; j < 7; j++) begin
      cyc(1, 0);
      check("latency_level", 32'(lv[0]), 32'(j >= 5));
      check("latency_rise", 32'(rs[0]), 32'(j == 5));
    end
    check("latency_glitch", 32'(g0), 0);

    f = 0;
    for (int j = 0; j < 11; j++) begin
      cyc(j < 3 ? 1'b0 : 1'b1, 0);
      f += int'(fl[0]);
      check("lowpulse_level", 32'(lv[0]), 1);
    end
    check("lowpulse_fall", f, 0);
    check("lowpulse_glitch", 32'(g0), 1);

    do_reset();
    r = 0;
    for (int j = 0; j < 17; j++) begin
      cyc(j < 9 ? bounce[j] : 1'b1, 0);
      r += int'(rs[0]);
      if (j == 9)  check("bounce_early", 32'(lv[0]), 0);
      if (j == 10) check("bounce_accept", 32'(lv[0]), 1);
    end
    check("bounce_rises", r, 1);
    check("bounce_glitch", 32'(g0), 2);
    check("bounce_level", 32'(lv[0]), 1);

    do_reset();
    for (int p = 1; p <= 6; p++) begin
      for (int j = 0; j < 8; j++) cyc(j < 2 ? 1'b1 : 1'b0, (p == 6) && (j == 4));
      check($sformatf("sat_glitch_p%0d", p), 32'(g1), (p == 6) ? 0 : (p > 3 ? 3 : p));
    end

    do_reset();
    r = 0; f = 0;
    for (int t = 0; t < 20; t++) begin
      a = (t < 16) ? ((t % 2) == 0) : 1'b0;
      for (int j = 0; j < 2; j++) begin
        cyc(a, 0);
        h.push_back(a);
        r += int'(rs[2]);
        f += int'(fl[2]);
        if (h.size() > 2) check("fast_delay", 32'(lv[2]), 32'(h[h.size() - 3]));
      end
    end
    check("fast_rises", r, 8);
    check("fast_falls", f, 8);
    check("fast_glitch", 32'(g2), 0);
    check("slow_glitch_seen", 32'(g0 != 0), 1);

    for (int j = 0; j < 5; j++) cyc(1, 0);
    check("prerst_level2", 32'(lv[2]), 1);
    do_reset();
    check("async_level2", 32'(lv[2]), 0);
    for (int j = 0; j < 7; j++) begin
      cyc(1, 0);
      check("relatency_rise", 32'(rs[0]), 32'(j == 5));
    end

    a = 1'b1;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) a = ~a;
      cyc(a, $urandom_range(0, 29) == 0);
      if ($urandom_range(0, 149) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
